// File: rtl/add_round_key_pipe.sv
// Two-stage AddRoundKey pipeline with a writable round-key table.
// It uses valid/ready handshakes, a bypass path and a sticky flag for out-of-range indices.
module add_round_key_pipe #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned NUM_KEYS = 11,
  parameter int unsigned IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_state,
  input  logic [IDX_W-1:0]  in_round,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_state,
  output logic [IDX_W-1:0]  out_round,
  output logic              err_idx,
  input  logic              err_clr
);

  logic [DATA_W-1:0] key_tbl_q [NUM_KEYS];
  logic [DATA_W-1:0] key_tbl_d [NUM_KEYS];

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_state_q, s1_state_d;
  logic [DATA_W-1:0] s1_key_q,   s1_key_d;
  logic [IDX_W-1:0]  s1_round_q, s1_round_d;
  logic              s1_bypass_q, s1_bypass_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_state_q, s2_state_d;
  logic [IDX_W-1:0]  s2_round_q, s2_round_d;

  logic              err_q, err_d;

  logic              s1_ready_c;
  logic              s2_ready_c;
  logic              accept_c;
  logic              rd_oob_c;
  logic              wr_oob_c;
  logic [DATA_W-1:0] lookup_key_c;

  // Handshake: a stage may load when it is empty or its successor drains.
  always_comb begin
    s2_ready_c = !s2_valid_q || out_ready;
    s1_ready_c = !s1_valid_q || s2_ready_c;
    accept_c   = in_valid && s1_ready_c;
  end

  // Out-of-range indices read as a zero key.
  always_comb begin
    lookup_key_c = '0;
    rd_oob_c     = (32'(in_round) >= NUM_KEYS);
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (in_round == IDX_W'(i)) begin
        lookup_key_c = key_tbl_q[i];
      end
    end
  end

  // The table updates at the edge, so a same-cycle accept sees the old key.
  always_comb begin
    key_tbl_d = key_tbl_q;
    wr_oob_c  = key_wr_en && (32'(key_wr_idx) >= NUM_KEYS);
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (key_wr_en && (key_wr_idx == IDX_W'(i))) begin
        key_tbl_d[i] = key_wr_data;
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_state_d  = s1_state_q;
    s1_key_d    = s1_key_q;
    s1_round_d  = s1_round_q;
    s1_bypass_d = s1_bypass_q;
    if (s1_ready_c) begin
      s1_valid_d = in_valid;
    end
    if (accept_c) begin
      s1_state_d  = in_state;
      s1_key_d    = lookup_key_c;
      s1_round_d  = in_round;
      s1_bypass_d = in_bypass;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_state_d = s2_state_q;
    s2_round_d = s2_round_q;
    if (s2_ready_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_state_d = s1_bypass_q ? s1_state_q : (s1_state_q ^ s1_key_q);
        s2_round_d = s1_round_q;
      end
    end
  end

  // A new error event takes priority over a same-cycle clear.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (wr_oob_c || (accept_c && !in_bypass && rd_oob_c)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        key_tbl_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_state_q  <= '0;
      s1_key_q    <= '0;
      s1_round_q  <= '0;
      s1_bypass_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_state_q  <= '0;
      s2_round_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      key_tbl_q   <= key_tbl_d;
      s1_valid_q  <= s1_valid_d;
      s1_state_q  <= s1_state_d;
      s1_key_q    <= s1_key_d;
      s1_round_q  <= s1_round_d;
      s1_bypass_q <= s1_bypass_d;
      s2_valid_q  <= s2_valid_d;
      s2_state_q  <= s2_state_d;
      s2_round_q  <= s2_round_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = s1_ready_c;
  assign out_valid = s2_valid_q;
  assign out_state = s2_state_q;
  assign out_round = s2_round_q;
  assign err_idx   = err_q;

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Randomised and directed bench for add_round_key_pipe.
// Expected results come from a key array and a transfer queue.
module tb_add_round_key_pipe;

  localparam int unsigned DATA_W   = 128;
  localparam int unsigned NUM_KEYS = 11;
  localparam int unsigned IDX_W    = 4;

  typedef struct packed {
    logic [DATA_W-1:0] st;
    logic [IDX_W-1:0]  rnd;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              key_wr_en;
  logic [IDX_W-1:0]  key_wr_idx;
  logic [DATA_W-1:0] key_wr_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_state;
  logic [IDX_W-1:0]  in_round;
  logic              in_bypass;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_state;
  logic [IDX_W-1:0]  out_round;
  logic              err_idx;
  logic              err_clr;

  add_round_key_pipe #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_round(in_round), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_round(out_round), .err_idx(err_idx), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] keys_m [NUM_KEYS];
  exp_t              exp_q [$];
  logic              err_exp;
  logic              stall_prev;
  logic [DATA_W-1:0] prev_state;
  logic [IDX_W-1:0]  prev_round;
  logic              last_ov;
  logic              last_ir;
  logic [DATA_W-1:0] last_os;
  int                acc_cnt;
  int                out_cnt;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_KEYS; i++) keys_m[i] = '0;
    exp_q.delete();
    err_exp    = 1'b0;
    stall_prev = 1'b0;
  endtask

  task automatic set_idle();
    key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    in_valid = 1'b0; in_state = '0; in_round = '0; in_bypass = 1'b0;
    err_clr = 1'b0;
  endtask

  // One clock: sample mid-low-phase, check against the model, apply edge effects.
  task automatic step();
    logic acc, oxf, set_e;
    logic [DATA_W-1:0] k;
    exp_t e;
    @(negedge clk);
    #1;
    last_ov = out_valid; last_ir = in_ready; last_os = out_state;
    check_eq("in_ready", 128'(in_ready), 128'((exp_q.size() < 2) || out_ready));
    check_eq("err_idx", 128'(err_idx), 128'(err_exp));
    if (stall_prev) begin
      check_eq("stall_valid", 128'(out_valid), 128'(1));
      check_eq("stall_state", out_state, prev_state);
      check_eq("stall_round", 128'(out_round), 128'(prev_round));
    end
    stall_prev = out_valid && !out_ready;
    prev_state = out_state; prev_round = out_round;
    oxf = out_valid && out_ready;
    acc = in_valid && in_ready;
    if (oxf) begin
      if (exp_q.size() == 0) begin
        check_eq("out_valid_empty", 128'(out_valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("out_state", out_state, e.st);
        check_eq("out_round", 128'(out_round), 128'(e.rnd));
        out_cnt++;
      end
    end
    if (acc) begin
      k = (int'(in_round) < NUM_KEYS) ? keys_m[in_round] : '0;
      e.st  = in_bypass ? in_state : (in_state ^ k);
      e.rnd = in_round;
      exp_q.push_back(e);
      acc_cnt++;
    end
    set_e = (key_wr_en && int'(key_wr_idx) >= NUM_KEYS) ||
            (acc && !in_bypass && int'(in_round) >= NUM_KEYS);
    if (key_wr_en && int'(key_wr_idx) < NUM_KEYS) keys_m[key_wr_idx] = key_wr_data;
    if (set_e) err_exp = 1'b1;
    else if (err_clr) err_exp = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_idle();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check_eq("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic write_key(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d);
    set_idle();
    key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = d;
    step();
    set_idle();
  endtask

  task automatic send(input logic [DATA_W-1:0] st, input logic [IDX_W-1:0] r,
                      input logic byp);
    set_idle();
    in_valid = 1'b1; in_state = st; in_round = r; in_bypass = byp;
    step();
    set_idle();
  endtask

  localparam logic [DATA_W-1:0] K1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [DATA_W-1:0] S1  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [DATA_W-1:0] R1  = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;

  logic [DATA_W-1:0] rs, k2_old;

  initial begin
    set_idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    acc_cnt = 0; out_cnt = 0;
    #12;
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_state", out_state, 128'(0));
    check_eq("rst_out_round", 128'(out_round), 128'(0));
    check_eq("rst_err", 128'(err_idx), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));

    // Test 1: known-answer with 2-cycle latency
    write_key(4'd1, K1);
    send(S1, 4'd1, 1'b0);
    step();
    check_eq("lat_not_yet", 128'(last_ov), 128'(0));
    step();
    check_eq("lat_valid", 128'(last_ov), 128'(1));
    check_eq("kat_state", last_os, R1);

    // Test 2: back-to-back with distinct keys
    for (int i = 0; i < 4; i++) write_key(IDX_W'(i), {4{$urandom}});
    out_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_state = {4{$urandom}}; in_round = IDX_W'(i);
      step();
      check_eq("b2b_in_ready", 128'(last_ir), 128'(1));
    end
    drain();
    check_eq("b2b_count", 128'(out_cnt), 128'(4));

    // Test 3: backpressure holds two and drains in order
    acc_cnt = 0; out_cnt = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_state = {4{$urandom}}; in_round = IDX_W'($urandom_range(0, 10));
      step();
    end
    check_eq("bp_accepts", 128'(acc_cnt), 128'(2));
    check_eq("bp_in_ready", 128'(last_ir), 128'(0));
    drain();
    check_eq("bp_drained", 128'(out_cnt), 128'(2));

    // Test 4: same-cycle write and accept on idx 2 uses the old key
    k2_old = {4{$urandom}};
    write_key(4'd2, k2_old);
    rs = {4{$urandom}};
    in_valid = 1'b1; in_state = rs; in_round = 4'd2;
    key_wr_en = 1'b1; key_wr_idx = 4'd2; key_wr_data = ~k2_old;
    step();
    set_idle();
    step(); step();
    check_eq("rbw_old_key", last_os, rs ^ k2_old);
    send(rs, 4'd2, 1'b0);
    step(); step();
    check_eq("rbw_new_key", last_os, rs ^ ~k2_old);

    // Test 5: error flag set, hold, clear and bypass immunity
    rs = {4{$urandom}};
    send(rs, 4'd11, 1'b0);
    step(); step();
    check_eq("oob_passthru", last_os, rs);
    check_eq("err_set", 128'(err_idx), 128'(1));
    step();
    check_eq("err_held", 128'(err_idx), 128'(1));
    err_clr = 1'b1; step(); set_idle(); step();
    check_eq("err_cleared", 128'(err_idx), 128'(0));
    write_key(4'd12, {4{$urandom}});
    step();
    check_eq("err_wr_oob", 128'(err_idx), 128'(1));
    key_wr_en = 1'b1; key_wr_idx = 4'd13; err_clr = 1'b1;
    step(); set_idle(); step();
    check_eq("err_set_wins", 128'(err_idx), 128'(1));
    err_clr = 1'b1; step(); set_idle();
    send(rs, 4'd15, 1'b1);
    step(); step();
    check_eq("byp_no_err", 128'(err_idx), 128'(0));
    check_eq("byp_state", last_os, rs);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      key_wr_en   = ($urandom_range(0, 4) == 0);
      key_wr_idx  = IDX_W'($urandom_range(0, 12));
      key_wr_data = {4{$urandom}};
      in_valid    = ($urandom_range(0, 3) != 0);
      in_state    = {4{$urandom}};
      in_round    = ($urandom_range(0, 9) == 0) ? IDX_W'($urandom_range(11, 15))
                                                : IDX_W'($urandom_range(0, 10));
      in_bypass   = ($urandom_range(0, 9) == 0);
      err_clr     = ($urandom_range(0, 9) == 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    // Test 6: reset with two in flight
    write_key(4'd1, K1);
    out_ready = 1'b0;
    send(S1, 4'd1, 1'b0);
    send(S1, 4'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("no_stale_out", 128'(last_ov), 128'(0));
    end
    send(S1, 4'd1, 1'b0);
    step(); step();
    check_eq("post_rst_key0", last_os, S1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
